// File: rtl/cycle_sequencer.sv
// rtl/cycle_sequencer.sv - multi-cycle instruction phase sequencer with memory-wait timeout
//
// Purpose : steps a datapath through FETCH -> DECODE -> EXEC -> [MEM] -> WB,
//           either continuously (run) or one instruction per step rising edge.
//           FETCH and MEM wait for mem_ack; a wait longer than MEM_TIMEOUT
//           cycles traps in ERR. A decoded halt instruction traps in HALT.
// Ports   : CLK, RESET_N (async, active-low)
//           run, step, halt_instr, need_mem, mem_ack   - control inputs
//           mem_req, en_fetch, en_decode, en_exec,
//           en_mem, en_wb, instr_done                  - phase outputs
//           halted, timeout_err, state[2:0]            - status outputs
//           cycle_count[CYC_W-1:0]                     - only with CYCLE_COUNTER_EN
// Options : define CYCLE_COUNTER_EN to add the busy-cycle counter and its port.
module cycle_sequencer #(
  parameter int CYC_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             run,
  input  logic             step,
  input  logic             halt_instr,
  input  logic             need_mem,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             en_fetch,
  output logic             en_decode,
  output logic             en_exec,
  output logic             en_mem,
  output logic             en_wb,
  output logic             instr_done,
  output logic             halted,
  output logic             timeout_err,
  output logic [2:0]       state
`ifdef CYCLE_COUNTER_EN
  ,
  output logic [CYC_W-1:0] cycle_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  if (CYC_W < 1 || MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_param
    $error("cycle_sequencer: CYC_W or MEM_TIMEOUT out of range");
  end

  // The limit cycle is the one where the counter already holds MEM_TIMEOUT-1
  // un-acked cycles; an ack there still wins over the timeout.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     cur, nxt;
  logic [7:0] wait_cnt;
  logic       need_q;
  logic       step_q;
  logic       run_mode;
  logic       step_edge;
  logic       start;

  assign step_edge = step & ~step_q;
  assign start     = run | step_edge;
  assign state     = cur;

  always_comb begin
    nxt         = cur;
    mem_req     = 1'b0;
    en_fetch    = 1'b0;
    en_decode   = 1'b0;
    en_exec     = 1'b0;
    en_mem      = 1'b0;
    en_wb       = 1'b0;
    instr_done  = 1'b0;
    halted      = 1'b0;
    timeout_err = 1'b0;
    case (cur)
      S_IDLE: begin
        halted = 1'b1;
        if (start) nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          en_fetch = 1'b1;
          nxt      = S_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          nxt = S_ERR;
        end
      end
      S_DECODE: begin
        en_decode = 1'b1;
        nxt       = halt_instr ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        en_exec = 1'b1;
        nxt     = need_q ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          en_mem = 1'b1;
          nxt    = S_WB;
        end else if (wait_cnt == WAIT_LAST) begin
          nxt = S_ERR;
        end
      end
      S_WB: begin
        en_wb      = 1'b1;
        instr_done = 1'b1;
        nxt        = (run_mode && run) ? S_FETCH : S_IDLE;
      end
      S_HALT: halted = 1'b1;
      S_ERR:  timeout_err = 1'b1;
      default: nxt = S_IDLE;
    endcase
  end

  // wait_cnt is zero whenever the previous cycle was not an un-acked request,
  // so it is already clear on entry to FETCH or MEM.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cur      <= S_IDLE;
      wait_cnt <= 8'd0;
      need_q   <= 1'b0;
      step_q   <= 1'b0;
      run_mode <= 1'b0;
    end else begin
      cur    <= nxt;
      step_q <= step;
      if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 8'd1;
      else                     wait_cnt <= 8'd0;
      if (cur == S_DECODE) need_q <= need_mem;
      // run wins over a coincident step edge, so it alone decides the mode.
      if (cur == S_IDLE && start) run_mode <= run;
    end
  end

`ifdef CYCLE_COUNTER_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cycle_count <= '0;
    end else if (cur inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      cycle_count <= cycle_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cycle_sequencer.sv
// tb/tb_cycle_sequencer.sv - self-checking bench for cycle_sequencer
module tb_cycle_sequencer;

  localparam int CYC_W       = 32;
  localparam int MEM_TIMEOUT = 15;

  logic             CLK = 1'b0;
  logic             RESET_N = 1'b0;
  logic             run = 1'b0, step = 1'b0, halt_instr = 1'b0, need_mem = 1'b0, mem_ack = 1'b0;
  logic             mem_req, en_fetch, en_decode, en_exec, en_mem, en_wb, instr_done;
  logic             halted, timeout_err;
  logic [2:0]       state;
`ifdef CYCLE_COUNTER_EN
  logic [CYC_W-1:0] cycle_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  cycle_sequencer #(.CYC_W(CYC_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .run(run), .step(step), .halt_instr(halt_instr), .need_mem(need_mem), .mem_ack(mem_ack),
    .mem_req(mem_req), .en_fetch(en_fetch), .en_decode(en_decode), .en_exec(en_exec),
    .en_mem(en_mem), .en_wb(en_wb), .instr_done(instr_done),
    .halted(halted), .timeout_err(timeout_err), .state(state)
`ifdef CYCLE_COUNTER_EN
    , .cycle_count(cycle_count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // {mem_req, en_fetch, en_decode, en_exec, en_mem, en_wb, instr_done, halted, timeout_err}
  function automatic logic [8:0] out_bundle();
    return {mem_req, en_fetch, en_decode, en_exec, en_mem, en_wb, instr_done, halted, timeout_err};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic r, input logic s, input logic h, input logic n, input logic a);
    run = r; step = s; halt_instr = h; need_mem = n; mem_ack = a;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    set_in(0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
  endtask

  // Reference model: an instruction is a list of phases still to visit.
  // Memory phases are held until acked; everything else lasts one cycle.
  int          m_cur;
  int          m_plan[$];
  bit          m_run_mode, m_stepq;
  int          m_waitc;
  int unsigned m_cnt;

  task automatic model_reset();
    m_cur = 0; m_plan.delete(); m_run_mode = 0; m_stepq = 0; m_waitc = 0; m_cnt = 0;
  endtask

  task automatic model_clock();
    bit edge_s;
    int nxt;
    edge_s  = step && !m_stepq;
    m_stepq = step;
    nxt     = m_cur;
    if (m_cur >= 1 && m_cur <= 5) m_cnt++;
    case (m_cur)
      0: if (run || edge_s) begin m_run_mode = run; m_plan = {2}; nxt = 1; end
      1, 4: begin
        if (mem_ack) nxt = m_plan.pop_front();
        else begin
          m_waitc++;
          if (m_waitc == MEM_TIMEOUT) begin nxt = 7; m_plan.delete(); end
        end
      end
      2: if (halt_instr) begin nxt = 6; m_plan.delete(); end
         else begin m_plan = need_mem ? {4, 5} : {5}; nxt = 3; end
      3: nxt = m_plan.pop_front();
      5: if (m_run_mode && run) begin nxt = 1; m_plan = {2}; end
         else nxt = 0;
      default: ;
    endcase
    if (nxt != m_cur) m_waitc = 0;
    m_cur = nxt;
  endtask

  function automatic logic [8:0] exp_bundle(input int s, input logic ack);
    return {s == 1 || s == 4, s == 1 && ack, s == 2, s == 3, s == 4 && ack,
            s == 5, s == 5, s == 0 || s == 6, s == 7};
  endfunction

  typedef struct {
    logic       r, s, h, n, a;
    logic [2:0] st;
    logic [4:0] en;    // {fetch, decode, exec, mem, wb}
    logic       req, done, hlt;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // reset state, asserted from time 0
    #2;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_outputs", 32'(out_bundle()), 32'b0_00000_0_1_0);

    // step with memory waits, then run+step together with run dropped in EXEC,
    // then continuous run without memory.
    tbl.push_back('{0,1,0,0,0, 3'd0, 5'b00000, 0,0,1});
    tbl.push_back('{0,0,0,0,0, 3'd1, 5'b00000, 1,0,0});
    tbl.push_back('{0,0,0,0,1, 3'd1, 5'b10000, 1,0,0});
    tbl.push_back('{0,0,0,1,0, 3'd2, 5'b01000, 0,0,0});
    tbl.push_back('{0,0,0,0,0, 3'd3, 5'b00100, 0,0,0});
    tbl.push_back('{0,0,0,0,0, 3'd4, 5'b00000, 1,0,0});
    tbl.push_back('{0,0,0,0,1, 3'd4, 5'b00010, 1,0,0});
    tbl.push_back('{0,0,0,0,0, 3'd5, 5'b00001, 0,1,0});
    tbl.push_back('{1,1,0,0,1, 3'd0, 5'b00000, 0,0,1});
    tbl.push_back('{1,1,0,0,1, 3'd1, 5'b10000, 1,0,0});
    tbl.push_back('{1,0,0,0,1, 3'd2, 5'b01000, 0,0,0});
    tbl.push_back('{0,0,0,0,1, 3'd3, 5'b00100, 0,0,0});
    tbl.push_back('{0,0,0,0,1, 3'd5, 5'b00001, 0,1,0});
    tbl.push_back('{1,0,0,0,1, 3'd0, 5'b00000, 0,0,1});
    for (int k = 0; k < 2; k++) begin
      tbl.push_back('{1,0,0,0,1, 3'd1, 5'b10000, 1,0,0});
      tbl.push_back('{1,0,0,0,1, 3'd2, 5'b01000, 0,0,0});
      tbl.push_back('{1,0,0,0,1, 3'd3, 5'b00100, 0,0,0});
      tbl.push_back('{1,0,0,0,1, 3'd5, 5'b00001, 0,1,0});
    end
    tbl.push_back('{0,0,0,0,1, 3'd1, 5'b10000, 1,0,0});
    tbl.push_back('{0,0,0,0,1, 3'd2, 5'b01000, 0,0,0});
    tbl.push_back('{0,0,0,0,1, 3'd3, 5'b00100, 0,0,0});
    tbl.push_back('{0,0,0,0,1, 3'd5, 5'b00001, 0,1,0});
    tbl.push_back('{0,0,0,0,0, 3'd0, 5'b00000, 0,0,1});

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].r, tbl[i].s, tbl[i].h, tbl[i].n, tbl[i].a);
      #3;
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("vec%0d_outputs", i), 32'(out_bundle()),
          32'({tbl[i].req, tbl[i].en, tbl[i].done, tbl[i].hlt, 1'b0}));
      tick();
    end
`ifdef CYCLE_COUNTER_EN
    chk("vec_cycle_count", cycle_count, 32'd23);
`endif

    // timeout: 15 un-acked FETCH cycles -> ERR, absorbing
    do_reset();
    set_in(0, 1, 0, 0, 0); tick();
    step = 0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      #3 chk($sformatf("to_wait%0d_state", i), 32'(state), 32'd1);
      tick();
    end
    #3;
    chk("to_err_state", 32'(state), 32'd7);
    chk("to_err_outputs", 32'(out_bundle()), 32'b0_00000_0_0_1);
`ifdef CYCLE_COUNTER_EN
    chk("to_cycle_count", cycle_count, 32'd15);
`endif
    set_in(1, 1, 0, 0, 1); tick(); tick();
    #3 chk("to_err_absorbing", 32'(state), 32'd7);

    // ack exactly on the limit cycle is accepted
    do_reset();
    set_in(0, 1, 0, 0, 0); tick();
    step = 0;
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) tick();
    mem_ack = 1;
    #3 chk("to_ack_limit_outputs", 32'(out_bundle()), 32'b1_10000_0_0_0);
    tick();
    #3 chk("to_ack_limit_state", 32'(state), 32'd2);

    // halt instruction: HALT, no en_exec, run/step ignored
    do_reset();
    set_in(0, 1, 0, 0, 1); tick();
    step = 0; tick();
    halt_instr = 1;
    #3 chk("halt_decode_outputs", 32'(out_bundle()), 32'b0_01000_0_0_0);
    tick();
    halt_instr = 0;
    for (int i = 0; i < 4; i++) begin
      run = 1; step = i[0];
      #3;
      chk($sformatf("halt%0d_state", i), 32'(state), 32'd6);
      chk($sformatf("halt%0d_outputs", i), 32'(out_bundle()), 32'b0_00000_0_1_0);
      tick();
    end

    // reset asserted mid-MEM
    do_reset();
    set_in(0, 1, 0, 1, 1); tick();
    step = 0; tick(); tick();
    mem_ack = 0; tick();
    chk("rst_pre_state", 32'(state), 32'd4);
    #1 RESET_N = 0;
    #1;
    chk("rst_mid_state", 32'(state), 32'd0);
    chk("rst_mid_outputs", 32'(out_bundle()), 32'b0_00000_0_1_0);
`ifdef CYCLE_COUNTER_EN
    chk("rst_mid_cycle_count", cycle_count, 32'd0);
`endif
    mem_ack = 1;
    tick();
    chk("rst_hold_outputs", 32'(out_bundle()), 32'b0_00000_0_1_0);
    RESET_N = 1;
    tick();
    #2 chk("rst_after_state", 32'(state), 32'd0);

    // randomized run against the phase-list model
    do_reset();
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      @(posedge CLK);
      if (RESET_N) model_clock();
      #1;
      if (!RESET_N) RESET_N = 1'b1;
      else if (m_cur >= 6 || $urandom_range(0, 79) == 0) begin
        RESET_N = 1'b0;
        model_reset();
      end
      if ($urandom_range(0, 15) == 0) run = ~run;
      step       = ($urandom_range(0, 2) == 0);
      halt_instr = ($urandom_range(0, 24) == 0);
      need_mem   = ($urandom_range(0, 1) == 0);
      mem_ack    = ($urandom_range(0, 3) != 0);
      #3;
      chk("rnd_state", 32'(state), 32'(m_cur));
      chk("rnd_outputs", 32'(out_bundle()), 32'(exp_bundle(m_cur, mem_ack)));
`ifdef CYCLE_COUNTER_EN
      chk("rnd_cycle_count", cycle_count, m_cnt);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 SHALL have parameter CYC_W, default 32: width of the cycle counter.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15: maximum number of un-acked memory wait cycles; legal range 1..255.
REQ-003 SHALL have port CLK  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port run  input  1  level; continuous instruction execution while high.
REQ-006 SHALL have port step  input  1  synchronous level; each rising edge requests one instruction while idle.
REQ-007 SHALL have port halt_instr  input  1  decoder flag, sampled in DECODE.
REQ-008 SHALL have port need_mem  input  1  instruction needs a MEM phase, sampled in DECODE.
REQ-009 SHALL have port mem_ack  input  1  memory completion.
REQ-010 SHALL have port mem_req  output  1  memory access request.
REQ-011 SHALL have ports en_fetch, en_decode, en_exec, en_mem, en_wb  output  1 each  datapath phase enables.
REQ-012 SHALL have port instr_done  output  1  one-cycle pulse on writeback.
REQ-013 SHALL have ports halted (output, 1), timeout_err (output, 1) and state (output, 3).

Function
REQ-014 SHALL implement the states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7, and drive the state output with the current encoding.
REQ-015 SHALL leave IDLE for FETCH when run=1 or a step rising edge occurs (step & ~step_q); if both occur in the same cycle, run takes priority and run mode is latched.
REQ-016 SHALL, in FETCH and MEM, assert mem_req=1 and stay in the state until mem_ack=1.
REQ-017 SHALL assert en_fetch or en_mem combinationally during the ack cycle only, then advance to DECODE (from FETCH) or WB (from MEM).
REQ-018 SHALL, in DECODE, assert en_decode for one cycle and latch need_mem; the next state is HALT if halt_instr=1, otherwise EXEC.
REQ-019 SHALL, in EXEC, assert en_exec for one cycle; the next state is MEM if need_mem was latched, otherwise WB.
REQ-020 SHALL, in WB, assert en_wb and instr_done for one cycle; the next state is FETCH if the mode is run and run=1, otherwise IDLE.
REQ-021 SHALL give a latency, from IDLE exit to instr_done, of 4 cycles without memory and 5 cycles with memory when mem_ack arrives in the first request cycle; each additional wait cycle adds 1.
REQ-022 SHALL treat run falling mid-instruction as follows: the current instruction completes, then the sequencer returns to IDLE.
REQ-023 SHALL ignore step edges outside IDLE; they are not queued.
REQ-024 SHALL clear the wait counter on entry to FETCH or MEM and increment it each mem_req cycle with mem_ack=0.
REQ-025 SHALL enter ERR after exactly MEM_TIMEOUT consecutive un-acked cycles; an ack in the same cycle as the limit is accepted and does not cause ERR.
REQ-026 SHALL ignore mem_ack outside FETCH and MEM.
REQ-027 SHALL assert halted=1 in IDLE and HALT.
REQ-028 SHALL make HALT absorbing: all enables=0, mem_req=0, exit only by reset.
REQ-029 SHALL make ERR absorbing with timeout_err=1, mem_req=0, all enables=0; exit only by reset.
REQ-030 SHALL drive all enables, mem_req and instr_done at 0 in IDLE.

Reset
REQ-031 SHALL, on RESET_N=0, immediately force state=IDLE, the wait counter to 0, the latched need_mem to 0, step_q to 0, the run-mode latch to 0, and the cycle count to 0.
REQ-032 SHALL hold the outputs mem_req=0, all en_*=0, instr_done=0, halted=1, timeout_err=0 while in reset.
REQ-033 SHALL abandon any in-flight instruction when reset is asserted mid-operation; no enable pulse follows.
REQ-034 SHALL, after reset release, leave IDLE no earlier than the first rising CLK edge.

Configuration
REQ-035 SHALL, with CYCLE_COUNTER_EN defined, add the output cycle_count (CYC_W bits), which increments each cycle the state is FETCH..WB, wraps modulo 2^CYC_W, and holds in IDLE/HALT/ERR.
REQ-036 SHALL, without CYCLE_COUNTER_EN, omit both the cycle_count port and its counter logic.

Verification
REQ-037 SHALL cover: run=1, need_mem=0, mem_ack tied 1 -> states 1,2,3,5 repeating; instr_done every 4 cycles.
REQ-038 SHALL cover: run=0, a single step pulse, need_mem=1, mem_ack=1 on the second request cycle of both FETCH and MEM -> exactly one instr_done after 7 cycles, then IDLE with halted=1.
REQ-039 SHALL cover: MEM_TIMEOUT=15 and mem_ack held 0 in FETCH -> ERR after exactly 15 cycles, timeout_err=1; a repeat with ack on cycle 15 -> DECODE, no error.
REQ-040 SHALL cover: halt_instr=1 in DECODE -> HALT, halted=1, no en_exec; run and step then ignored until reset.
REQ-041 SHALL cover: RESET_N pulsed low during MEM -> immediately IDLE with outputs at reset values; the cycle count (if enabled) reads 0.
REQ-042 SHALL cover: run and step rising together in IDLE -> continuous run mode; run dropped in EXEC -> WB completes, then IDLE.
